// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - ASCII W/R command parser between the UART and the PWM duty register file.
// Replies "K\r\n" for writes, hex duty + "\r\n" for reads and "?\r\n" for malformed commands.
module uart_cmd_parser #(
    parameter int NUM_CH     = 4,
    parameter int HEX_DIGITS = 2,
    parameter int CH_W       = 4,
    localparam int DATA_W    = 4 * HEX_DIGITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_received,
    input  logic [7:0]        rx_byte,
    input  logic              rx_error,
    output logic              tx_transmit,
    output logic [7:0]        tx_byte,
    input  logic              tx_busy,
    output logic              wr_en,
    output logic [CH_W-1:0]   wr_ch,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_CH, S_GET_HEX, S_GET_CR, S_FLUSH, S_EXEC, S_SEND, S_SEND_WAIT
    } state_t;

    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam int         RLEN  = HEX_DIGITS + 2;
    localparam int         RW    = 8 * RLEN;
    localparam int         REM_W = $clog2(RLEN);
    localparam int         CNT_W = $clog2(HEX_DIGITS + 1);
    localparam logic [4:0] NUM_CH_L  = 5'(NUM_CH);
    localparam logic [RW-1:0] REPLY_ERR = RW'({8'h3F, CR, LF}) << (RW - 24);
    localparam logic [RW-1:0] REPLY_OK  = RW'({8'h4B, CR, LF}) << (RW - 24);

    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            return {1'b1, c[3:0] + 4'd9};
        else
            return 5'b0;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'b0, n} : 8'h37 + {4'b0, n};
    endfunction

    state_t             state_q;
    logic               op_write_q;
    logic [DATA_W-1:0]  acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RW-1:0]      reply_q;
    logic [REM_W-1:0]   rem_q;
    logic               tx_transmit_q;
    logic               wr_en_q;
    logic [CH_W-1:0]    wr_ch_q;
    logic [DATA_W-1:0]  wr_data_q;
    logic               overrun_q;

    logic [4:0]         hex_d;
    logic               ch_ok;
    logic               parse_bad;
    logic [DATA_W-1:0]  acc_d;
    logic [RW-1:0]      rd_reply;

    assign hex_d = hex_decode(rx_byte);
    assign ch_ok = (rx_byte >= 8'h30) && (rx_byte <= 8'h39) && ({1'b0, rx_byte[3:0]} < NUM_CH_L);
    assign acc_d = (acc_q << 4) | DATA_W'(hex_d[3:0]);

    // FLUSH treats every byte as bad so a CR there takes the same "?" reply path.
    always_comb begin
        parse_bad = 1'b0;
        case (state_q)
            S_GET_CH:  parse_bad = !ch_ok;
            S_GET_HEX: parse_bad = !hex_d[4];
            S_GET_CR:  parse_bad = (rx_byte != CR);
            S_FLUSH:   parse_bad = 1'b1;
            default:   parse_bad = 1'b0;
        endcase
    end

    always_comb begin
        rd_reply = '0;
        for (int i = 0; i < HEX_DIGITS; i++)
            rd_reply[RW-1-8*i -: 8] = hex_char(rd_data[DATA_W-1-4*i -: 4]);
        rd_reply[15:0] = {CR, LF};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_write_q    <= 1'b0;
            acc_q         <= '0;
            cnt_q         <= '0;
            reply_q       <= '0;
            rem_q         <= '0;
            tx_transmit_q <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_ch_q       <= '0;
            wr_data_q     <= '0;
            overrun_q     <= 1'b0;
        end else begin
            wr_en_q   <= 1'b0;
            overrun_q <= rx_received && (state_q inside {S_EXEC, S_SEND, S_SEND_WAIT});
            case (state_q)
                S_IDLE: begin
                    if (rx_received) begin
                        if (rx_byte == 8'h57 || rx_byte == 8'h77) begin
                            op_write_q <= 1'b1;
                            state_q    <= S_GET_CH;
                        end else if (rx_byte == 8'h52 || rx_byte == 8'h72) begin
                            op_write_q <= 1'b0;
                            state_q    <= S_GET_CH;
                        end else if (rx_byte != LF && rx_byte != CR) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_GET_CH, S_GET_HEX, S_GET_CR, S_FLUSH: begin
                    if (rx_error) begin
                        state_q <= S_IDLE;
                    end else if (rx_received) begin
                        if (parse_bad) begin
                            if (rx_byte == CR) begin
                                reply_q       <= REPLY_ERR;
                                rem_q         <= REM_W'(2);
                                tx_transmit_q <= 1'b1;
                                state_q       <= S_SEND;
                            end else begin
                                state_q <= S_FLUSH;
                            end
                        end else begin
                            case (state_q)
                                S_GET_CH: begin
                                    wr_ch_q <= CH_W'(rx_byte[3:0]);
                                    acc_q   <= '0;
                                    cnt_q   <= '0;
                                    state_q <= op_write_q ? S_GET_HEX : S_GET_CR;
                                end
                                S_GET_HEX: begin
                                    acc_q <= acc_d;
                                    cnt_q <= cnt_q + 1'b1;
                                    if (cnt_q == CNT_W'(HEX_DIGITS - 1))
                                        state_q <= S_GET_CR;
                                end
                                S_GET_CR: begin
                                    // Strobe is registered here so it is high during the EXEC cycle.
                                    if (op_write_q) begin
                                        wr_en_q   <= 1'b1;
                                        wr_data_q <= acc_q;
                                    end
                                    state_q <= S_EXEC;
                                end
                                default: state_q <= S_FLUSH;
                            endcase
                        end
                    end
                end
                S_EXEC: begin
                    reply_q       <= op_write_q ? REPLY_OK : rd_reply;
                    rem_q         <= op_write_q ? REM_W'(2) : REM_W'(RLEN - 1);
                    tx_transmit_q <= 1'b1;
                    state_q       <= S_SEND;
                end
                S_SEND: begin
                    if (tx_busy) begin
                        tx_transmit_q <= 1'b0;
                        state_q       <= S_SEND_WAIT;
                    end
                end
                S_SEND_WAIT: begin
                    if (!tx_busy) begin
                        if (rem_q != '0) begin
                            rem_q         <= rem_q - 1'b1;
                            reply_q       <= reply_q << 8;
                            tx_transmit_q <= 1'b1;
                            state_q       <= S_SEND;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_transmit = tx_transmit_q;
    assign tx_byte     = reply_q[RW-1 -: 8];
    assign wr_en       = wr_en_q;
    assign wr_ch       = wr_ch_q;
    assign wr_data     = wr_data_q;
    assign busy        = (state_q != S_IDLE);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed self-checking bench for uart_cmd_parser.
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_received = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_error = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_transmit;
    logic [7:0] tx_byte;
    logic       wr_en;
    logic [3:0] wr_ch;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       busy;
    logic       overrun;

    logic [7:0] duty [0:3];
    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int ovr_cnt = 0;
    int ovr0;

    uart_cmd_parser #(.NUM_CH(4), .HEX_DIGITS(2), .CH_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_received (rx_received),
        .rx_byte     (rx_byte),
        .rx_error    (rx_error),
        .tx_transmit (tx_transmit),
        .tx_byte     (tx_byte),
        .tx_busy     (tx_busy),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    assign rd_data = (wr_ch < 4'd4) ? duty[wr_ch[1:0]] : 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            duty[0] <= 8'h00;
            duty[1] <= 8'h3C;
            duty[2] <= 8'h00;
            duty[3] <= 8'h00;
        end else if (wr_en) begin
            duty[wr_ch[1:0]] <= wr_data;
        end
    end

    always @(posedge clk) if (wr_en) wr_cnt <= wr_cnt + 1;
    always @(posedge clk) if (overrun) ovr_cnt <= ovr_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte = b;
        rx_received = 1'b1;
        @(posedge clk); #1;
        rx_received = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Plays the UART side: waits for a request, holds tx_busy low a while, then acknowledges.
    task automatic expect_tx(input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (tx_transmit !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, 32'(tx_transmit), 32'd1);
        chk({tag, "_byte"}, 32'(tx_byte), 32'(exp));
        repeat (2) @(negedge clk);
        chk({tag, "_hold"}, 32'(tx_transmit), 32'd1);
        tx_busy = 1'b1;
        @(negedge clk);
        chk({tag, "_drop"}, 32'(tx_transmit), 32'd0);
        repeat (2) @(negedge clk);
        tx_busy = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_tx_transmit", 32'(tx_transmit), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_ch", 32'(wr_ch), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;

        // Write command with exact wr_en / tx_transmit latency
        send_str("W2A5\r");
        @(negedge clk);
        chk("w2a5_wr_en", 32'(wr_en), 32'd1);
        chk("w2a5_wr_ch", 32'(wr_ch), 32'd2);
        chk("w2a5_wr_data", 32'(wr_data), 32'hA5);
        chk("w2a5_tx_early", 32'(tx_transmit), 32'd0);
        @(negedge clk);
        chk("w2a5_wr_en_single", 32'(wr_en), 32'd0);
        chk("w2a5_tx_lat", 32'(tx_transmit), 32'd1);
        expect_tx(8'h4B, "w2a5_r0");
        expect_tx(8'h0D, "w2a5_r1");
        expect_tx(8'h0A, "w2a5_r2");
        @(negedge clk);
        chk("w2a5_idle", 32'(busy), 32'd0);
        chk("w2a5_wr_cnt", 32'(wr_cnt), 32'd1);

        send_byte(8'h0A);
        @(negedge clk);
        chk("lf_idle", 32'(busy), 32'd0);

        // Read back channel 1
        send_str("r1\r");
        expect_tx(8'h33, "r1_r0");
        expect_tx(8'h43, "r1_r1");
        expect_tx(8'h0D, "r1_r2");
        expect_tx(8'h0A, "r1_r3");
        chk("r1_no_wr", 32'(wr_cnt), 32'd1);
        chk("r1_wr_ch", 32'(wr_ch), 32'd1);

        // Channel out of range
        send_str("W9FF");
        @(negedge clk);
        chk("w9ff_no_tx", 32'(tx_transmit), 32'd0);
        chk("w9ff_busy", 32'(busy), 32'd1);
        send_byte(8'h0D);
        expect_tx(8'h3F, "w9ff_r0");
        expect_tx(8'h0D, "w9ff_r1");
        expect_tx(8'h0A, "w9ff_r2");
        chk("w9ff_no_wr", 32'(wr_cnt), 32'd1);

        // Bad hex digit, then lowercase write
        send_str("W0G\r");
        expect_tx(8'h3F, "w0g_r0");
        expect_tx(8'h0D, "w0g_r1");
        expect_tx(8'h0A, "w0g_r2");
        chk("w0g_no_wr", 32'(wr_cnt), 32'd1);
        send_str("w0ff\r");
        @(negedge clk);
        chk("w0ff_wr_en", 32'(wr_en), 32'd1);
        chk("w0ff_wr_ch", 32'(wr_ch), 32'd0);
        chk("w0ff_wr_data", 32'(wr_data), 32'hFF);
        expect_tx(8'h4B, "w0ff_r0");
        expect_tx(8'h0D, "w0ff_r1");
        expect_tx(8'h0A, "w0ff_r2");
        chk("w0ff_wr_cnt", 32'(wr_cnt), 32'd2);

        // Framing error abandons a partial command
        send_str("W1");
        @(posedge clk); #1;
        rx_error = 1'b1;
        @(posedge clk); #1;
        rx_error = 1'b0;
        @(negedge clk);
        chk("rxerr_idle", 32'(busy), 32'd0);
        chk("rxerr_no_tx", 32'(tx_transmit), 32'd0);
        send_str("W11\r");
        expect_tx(8'h3F, "w11_r0");
        expect_tx(8'h0D, "w11_r1");
        expect_tx(8'h0A, "w11_r2");
        chk("w11_no_wr", 32'(wr_cnt), 32'd2);
        chk("w11_wr_ch", 32'(wr_ch), 32'd1);

        // Bytes arriving during the reply are dropped with overrun
        ovr0 = ovr_cnt;
        send_str("W012\r");
        send_str("R0\r");
        repeat (2) @(negedge clk);
        chk("ovr_count", 32'(ovr_cnt - ovr0), 32'd3);
        chk("ovr_wr_data", 32'(wr_data), 32'h12);
        expect_tx(8'h4B, "ovr_r0");
        expect_tx(8'h0D, "ovr_r1");
        expect_tx(8'h0A, "ovr_r2");
        @(negedge clk);
        chk("ovr_idle", 32'(busy), 32'd0);
        chk("ovr_wr_cnt", 32'(wr_cnt), 32'd3);

        // Asynchronous reset in the middle of a reply
        send_str("R0\r");
        n = 0;
        @(negedge clk);
        while (tx_transmit !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rd0_req", 32'(tx_transmit), 32'd1);
        chk("rd0_byte", 32'(tx_byte), 32'h31);
        rst = 1'b1;
        #1;
        chk("arst_tx_drop", 32'(tx_transmit), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_still_idle", 32'(tx_transmit), 32'd0);
        chk("arst_no_wr", 32'(wr_cnt), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Downstream consumer of the UART receiver and upstream driver of the UART transmitter.
- Parses ASCII commands arriving as one-cycle `received` strobes. Issues single-cycle write strobes to the PWM duty register file, or reads it back.
- Sends an ASCII reply through the UART transmit handshake.
- Sits between the UART and the PWM channel bank in the top level.

Parameters:
- NUM_CH, 4, number of PWM channels; legal 1..10, channel addressed by one ASCII digit '0'..'9'.
- HEX_DIGITS, 2, hex digits per duty value; DATA_W = 4*HEX_DIGITS.
- CH_W, 4, width of channel index ports.

Ports:
- clk  in  1  master clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_received  in  1  one-cycle strobe, rx_byte valid.
- rx_byte  in  8  received byte.
- rx_error  in  1  one-cycle receive framing error strobe.
- tx_transmit  out  1  request to UART to send tx_byte.
- tx_byte  out  8  byte to send.
- tx_busy  in  1  UART is_transmitting.
- wr_en  out  1  one-cycle duty write strobe.
- wr_ch  out  CH_W  channel for write/read.
- wr_data  out  DATA_W  duty value for write.
- rd_data  in  DATA_W  duty of channel wr_ch; combinational from register file.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  one-cycle pulse when a byte is dropped during reply.

Behaviour:
- Reset: all outputs 0, state IDLE, hex accumulator 0, reply buffer empty.
- Grammar: 'W'|'w' digit hexN CR writes; 'R'|'r' digit CR reads.
  - Hex accepts 0-9, A-F, a-f; MSB digit first.
  - LF (0x0A) is ignored in IDLE only.
- States and transitions:
  - IDLE:
    - W/w -> GET_CH (op=write).
    - R/r -> GET_CH (op=read).
    - LF: stay.
    - CR: stay, no reply.
    - Any other byte -> FLUSH.
  - GET_CH:
    - Digit < NUM_CH: latch wr_ch. Write -> GET_HEX with digit count 0; read -> GET_CR.
    - Any other byte -> FLUSH.
  - GET_HEX:
    - Valid hex digit: acc = {acc[DATA_W-5:0], nibble}.
    - After HEX_DIGITS digits -> GET_CR.
    - Non-hex -> FLUSH.
  - GET_CR:
    - CR -> EXEC.
    - Anything else -> FLUSH.
  - FLUSH: discard bytes until CR, then load reply "?\r\n" -> SEND.
  - EXEC (1 cycle):
    - Write: wr_en=1 with wr_data=acc; load reply "K\r\n".
    - Read: capture rd_data; load reply as HEX_DIGITS uppercase hex chars then "\r\n".
    - -> SEND.
  - SEND: drive tx_byte = current reply byte, tx_transmit=1; when tx_busy=1, drop tx_transmit -> SEND_WAIT.
  - SEND_WAIT: when tx_busy=0, advance reply pointer; more bytes -> SEND, else -> IDLE.
- tx_transmit stays high until tx_busy is seen high and is deasserted the cycle after. This is required because the UART holds in its recover state while transmit stays asserted.
- Bytes arriving in EXEC/SEND/SEND_WAIT are dropped; each drop pulses overrun for 1 cycle.
- rx_error in any parse state (GET_CH..FLUSH): abandon command, no reply, -> IDLE.
  - rx_error in IDLE, SEND or SEND_WAIT is ignored.
  - rx_error and rx_received in the same cycle: rx_error wins, byte discarded.
- Latency:
  - wr_en asserts exactly 1 cycle after the rx_received strobe carrying CR.
  - tx_transmit asserts 2 cycles after that strobe.
- wr_ch holds its value until the next GET_CH; wr_data holds until the next EXEC write.
- Async rst mid-reply: tx_transmit drops immediately, reply is aborted, no wr_en is issued.

Test Plan:
- "W2A5\r" -> wr_en single pulse with wr_ch=2, wr_data=0xA5, 1 cycle after CR strobe; UART sends 0x4B,0x0D,0x0A.
- rd_data=0x3C for ch1, "r1\r" -> no wr_en; sends 0x33,0x43,0x0D,0x0A; each tx_transmit holds until tx_busy=1.
- "W9FF\r" with NUM_CH=4 -> FLUSH, no wr_en; sends "?\r\n" only after the CR.
- "W0G\r" -> "?\r\n"; the following "w0ff\r" writes 0xFF to ch0 (lowercase accepted).
- "W1" then rx_error pulse, then "W11\r" -> no reply for the aborted command; second command parses as ch1 with hex '1' then CR → FLUSH → "?\r\n".
- Send "W012\r" then "R0\r" back-to-back during the reply -> overrun pulses once per dropped byte; reply for the first command completes intact; rst asserted mid-reply -> tx_transmit=0 in the same cycle.
